// File: rtl/sdram_memtest_pkg.sv
// Shared types and constants for the SDRAM memory tester.
// Holds the FSM state encoding, the LFSR tap mask and the default bus widths.
package sdram_memtest_pkg;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam int          DEF_ADDR_W   = 24;
    localparam int          DEF_DATA_W   = 16;
    localparam int          DEF_ERRCNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_NEXT,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/sdram_memtest_if.sv
// Request/response bus between the tester (master) and the SDRAM controller (slave).
interface sdram_memtest_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);

    logic              sdram_req;
    logic              sdram_rh_wl;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_data_w;
    logic              sdram_ack;
    logic [DATA_W-1:0] sdram_data_r;
    logic              sdram_data_r_en;

    modport master (
        output sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w,
        input  sdram_ack, sdram_data_r, sdram_data_r_en
    );

    modport slave (
        input  sdram_req, sdram_rh_wl, sdram_addr, sdram_data_w,
        output sdram_ack, sdram_data_r, sdram_data_r_en
    );

endinterface

// File: rtl/sdram_memtest_lfsr16_step.sv
// Combinational next state of the 16-bit Galois LFSR that generates the test pattern.
module lfsr16_step
    import sdram_memtest_pkg::*;
(
    input  logic [15:0] cur,
    output logic [15:0] nxt
);

    assign nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);

endmodule

// File: rtl/sdram_memtest.sv
// Self-contained SDRAM tester: writes an LFSR pattern over 0..LAST_ADDR, reads it back and
// compares, reporting error count, first-failure details and a handshake watchdog.
module sdram_memtest
    import sdram_memtest_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
    parameter logic [15:0]       SEED      = 16'hACE1,
    parameter int                TIMEOUT   = 1023,
    parameter int                ERRCNT_W  = DEF_ERRCNT_W
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_exp,
    output logic [DATA_W-1:0]   first_err_got,
    sdram_memtest_if.master     bus
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [WD_W-1:0]   wd_cnt;
    logic              req;
    logic              rh_wl;
    logic [DATA_W-1:0] expect_word;
    logic              at_last;
    logic              cmp_now;
    logic              mismatch;
    logic              abort;

    lfsr16_step u_step (
        .cur (lfsr),
        .nxt (lfsr_next)
    );

    assign bus.sdram_req    = req;
    assign bus.sdram_rh_wl  = rh_wl;
    assign bus.sdram_addr   = addr;
    assign bus.sdram_data_w = expect_word;

    assign expect_word = DATA_W'(lfsr);
    assign at_last     = (addr == LAST_ADDR);
    assign mismatch    = (bus.sdram_data_r != expect_word);

    // A read may complete in the same cycle it is acked, so compare in RD_REQ as well.
    assign cmp_now = bus.sdram_data_r_en &&
                     (((state == S_RD_REQ) && req && bus.sdram_ack) || (state == S_RD_WAIT));

    assign abort = (wd_cnt == WD_W'(TIMEOUT)) &&
                   (((state == S_WR_REQ)  && !bus.sdram_ack) ||
                    ((state == S_RD_REQ)  && !(req && bus.sdram_ack)) ||
                    ((state == S_RD_WAIT) && !bus.sdram_data_r_en));

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state          <= S_IDLE;
            addr           <= '0;
            lfsr           <= '0;
            wd_cnt         <= '0;
            req            <= 1'b0;
            rh_wl          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
        end else begin
            wd_cnt <= '0;
            if (cmp_now && mismatch) begin
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                    first_err_addr <= addr;
                    first_err_exp  <= expect_word;
                    first_err_got  <= bus.sdram_data_r;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_WR_REQ;
                        addr           <= '0;
                        lfsr           <= SEED;
                        req            <= 1'b1;
                        rh_wl          <= 1'b0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_exp  <= '0;
                        first_err_got  <= '0;
                    end
                end
                S_WR_REQ: begin
                    if (bus.sdram_ack) begin
                        req <= 1'b0;
                        if (at_last) begin
                            state <= S_RD_REQ;
                            addr  <= '0;
                            lfsr  <= SEED;
                            rh_wl <= 1'b1;
                        end else begin
                            state <= S_WR_NEXT;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_WR_NEXT: begin
                    addr  <= addr + 1'b1;
                    lfsr  <= lfsr_next;
                    req   <= 1'b1;
                    state <= S_WR_REQ;
                end
                // Entered from the final write with req low, so req is raised one cycle later.
                S_RD_REQ: begin
                    if (!req) begin
                        req    <= 1'b1;
                        wd_cnt <= wd_cnt + 1'b1;
                    end else if (bus.sdram_ack) begin
                        req   <= 1'b0;
                        state <= bus.sdram_data_r_en ? S_RD_NEXT : S_RD_WAIT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.sdram_data_r_en)
                        state <= S_RD_NEXT;
                    else
                        wd_cnt <= wd_cnt + 1'b1;
                end
                S_RD_NEXT: begin
                    if (at_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !timeout;
                    end else begin
                        addr  <= addr + 1'b1;
                        lfsr  <= lfsr_next;
                        req   <= 1'b1;
                        state <= S_RD_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (abort) begin
                state   <= S_DONE;
                req     <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_memtest.sv
// Self-checking bench for sdram_memtest: two DUT configurations driven by a randomized
// behavioural SDRAM model, with results checked against a pattern computed from the LFSR rule.
module tb_sdram_memtest;

    localparam int TO = 1023;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    always #5 clk = ~clk;

    logic        busy_a, done_a, pass_a, timeout_a;
    logic [15:0] err_count_a;
    logic [23:0] first_err_addr_a;
    logic [15:0] first_err_exp_a, first_err_got_a;

    logic        busy_b, done_b, pass_b, timeout_b;
    logic [3:0]  err_count_b;
    logic [23:0] first_err_addr_b;
    logic [15:0] first_err_exp_b, first_err_got_b;

    sdram_memtest_if #(.ADDR_W(24), .DATA_W(16)) bus_a ();
    sdram_memtest_if #(.ADDR_W(24), .DATA_W(16)) bus_b ();

    sdram_memtest #(.LAST_ADDR(24'd15), .TIMEOUT(TO)) dut_a (
        .clk(clk), .reset_l(reset_l), .start(start_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
        .err_count(err_count_a), .first_err_addr(first_err_addr_a),
        .first_err_exp(first_err_exp_a), .first_err_got(first_err_got_a),
        .bus(bus_a.master)
    );

    sdram_memtest #(.LAST_ADDR(24'd31), .ERRCNT_W(4), .TIMEOUT(TO)) dut_b (
        .clk(clk), .reset_l(reset_l), .start(start_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
        .err_count(err_count_b), .first_err_addr(first_err_addr_b),
        .first_err_exp(first_err_exp_b), .first_err_got(first_err_got_b),
        .bus(bus_b.master)
    );

    logic [15:0] probe_in;
    logic [15:0] probe_out;
    lfsr16_step u_probe (.cur(probe_in), .nxt(probe_out));

    int checks = 0;
    int failures = 0;

    // SDRAM model state, one slot per DUT.
    bit          never_ack [2];
    bit          fault0    [2];
    bit          invert    [2];
    bit          same_cyc  [2];
    int          wait_cnt  [2];
    int          rd_cnt    [2];
    bit          rd_pend   [2];
    logic [15:0] rd_val    [2];
    logic [15:0] mem       [2][32];
    int          acks      [2];
    int          proto_err [2];
    bit          seen_req  [2];
    logic [23:0] p_addr    [2];
    logic [15:0] p_data    [2];
    logic        p_rh      [2];

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        return (v / 16'd2) ^ (((v % 16'd2) != 16'd0) ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] ref_pat(input int n);
        logic [15:0] v = 16'hACE1;
        for (int k = 0; k < n; k++) v = ref_step(v);
        return v;
    endfunction

    task automatic model_step(input int i, input logic req, input logic rh,
                              input logic [23:0] addr, input logic [15:0] dw,
                              output logic ack, output logic den, output logic [15:0] dr);
        logic [15:0] v;
        ack = 1'b0;
        den = 1'b0;
        dr  = rd_val[i];
        if (!reset_l) begin
            rd_pend[i]  = 1'b0;
            seen_req[i] = 1'b0;
            wait_cnt[i] = $urandom_range(0, 5);
        end else begin
            if (req && seen_req[i] && ({addr, dw, rh} != {p_addr[i], p_data[i], p_rh[i]}))
                proto_err[i]++;
            if (req && rd_pend[i])
                proto_err[i]++;
            if (rd_pend[i]) begin
                if (rd_cnt[i] == 0) begin
                    den = 1'b1;
                    rd_pend[i] = 1'b0;
                end else begin
                    rd_cnt[i]--;
                end
            end else if (req && !never_ack[i]) begin
                if (wait_cnt[i] == 0) begin
                    ack = 1'b1;
                    acks[i]++;
                    if (!rh) begin
                        mem[i][addr[4:0]] = dw;
                    end else begin
                        v = mem[i][addr[4:0]];
                        if (fault0[i] && addr == 24'd0) v = 16'hACE0;
                        if (invert[i]) v = ~v;
                        rd_val[i] = v;
                        dr = v;
                        if (same_cyc[i]) begin
                            den = 1'b1;
                        end else begin
                            rd_pend[i] = 1'b1;
                            rd_cnt[i]  = $urandom_range(0, 4);
                        end
                    end
                    wait_cnt[i] = same_cyc[i] ? 0 : $urandom_range(0, 5);
                end else begin
                    wait_cnt[i]--;
                end
            end
            seen_req[i] = req && !ack;
            p_addr[i] = addr;
            p_data[i] = dw;
            p_rh[i]   = rh;
        end
    endtask

    always @(negedge clk)
        model_step(0, bus_a.sdram_req, bus_a.sdram_rh_wl, bus_a.sdram_addr, bus_a.sdram_data_w,
                   bus_a.sdram_ack, bus_a.sdram_data_r_en, bus_a.sdram_data_r);

    always @(negedge clk)
        model_step(1, bus_b.sdram_req, bus_b.sdram_rh_wl, bus_b.sdram_addr, bus_b.sdram_data_w,
                   bus_b.sdram_ack, bus_b.sdram_data_r_en, bus_b.sdram_data_r);

    task automatic run_a(input bit poke, input int bound, output int cycles, output bit expired);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        cycles  = 1;
        expired = 1'b1;
        while (cycles < bound) begin
            if (done_a) begin
                expired = 1'b0;
                break;
            end
            start_a = poke && (cycles % 37 == 0);
            @(negedge clk);
            cycles++;
        end
        start_a = 1'b0;
    endtask

    task automatic run_b(input int bound, output bit expired);
        int cycles = 1;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        expired = 1'b1;
        while (cycles < bound) begin
            if (done_b) begin
                expired = 1'b0;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({busy_a, done_a, pass_a, timeout_a, bus_a.sdram_req, bus_a.sdram_rh_wl} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags_a: got %b expected 000000",
                     {busy_a, done_a, pass_a, timeout_a, bus_a.sdram_req, bus_a.sdram_rh_wl});
        end
        checks++;
        if ({err_count_a, first_err_addr_a, first_err_exp_a, first_err_got_a,
             bus_a.sdram_addr, bus_a.sdram_data_w} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_values_a: err=%0h addr=%0h data_w=%0h expected all 0",
                     err_count_a, bus_a.sdram_addr, bus_a.sdram_data_w);
        end
        checks++;
        if ({busy_b, done_b, pass_b, timeout_b, bus_b.sdram_req, err_count_b,
             first_err_addr_b, first_err_exp_b, first_err_got_b} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_b: busy=%b req=%b err=%0h expected all 0",
                     busy_b, bus_b.sdram_req, err_count_b);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk) reset_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lfsr();
        for (int k = 0; k < 6; k++) begin
            probe_in = 16'($urandom_range(1, 16'hFFFF));
            #1;
            checks++;
            if (probe_out !== ref_step(probe_in)) begin
                failures++;
                $display("[TB] FAIL lfsr_step(%0h): got %0h expected %0h",
                         probe_in, probe_out, ref_step(probe_in));
            end
        end
    endtask

    task automatic test_clean(input bit same);
        int cycles;
        bit expired;
        int bad = 0;
        same_cyc[0] = same;
        acks[0] = 0;
        proto_err[0] = 0;
        run_a(1'b0, 5000, cycles, expired);
        checks++;
        if (expired || !done_a) begin
            failures++;
            $display("[TB] FAIL clean_done(same=%0d): done=%b after %0d cycles expected 1",
                     same, done_a, cycles);
        end
        checks++;
        if ({pass_a, timeout_a, busy_a} !== 3'b100 || err_count_a !== 16'd0) begin
            failures++;
            $display("[TB] FAIL clean_result(same=%0d): pass=%b timeout=%b busy=%b err=%0d expected 1 0 0 0",
                     same, pass_a, timeout_a, busy_a, err_count_a);
        end
        checks++;
        if (acks[0] != 32) begin
            failures++;
            $display("[TB] FAIL clean_acks(same=%0d): got %0d expected 32", same, acks[0]);
        end
        checks++;
        if (mem[0][0] !== 16'hACE1 || mem[0][1] !== 16'hE270) begin
            failures++;
            $display("[TB] FAIL clean_first_words: got %0h %0h expected ace1 e270",
                     mem[0][0], mem[0][1]);
        end
        for (int k = 0; k < 16; k++) if (mem[0][k] !== ref_pat(k)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL clean_pattern: %0d words differ, expected 0", bad);
        end
        checks++;
        if (proto_err[0] != 0) begin
            failures++;
            $display("[TB] FAIL clean_handshake: %0d violations expected 0", proto_err[0]);
        end
        same_cyc[0] = 1'b0;
    endtask

    task automatic test_fault();
        int cycles;
        bit expired;
        fault0[0] = 1'b1;
        run_a(1'b0, 5000, cycles, expired);
        checks++;
        if (expired || pass_a !== 1'b0 || err_count_a !== 16'd1) begin
            failures++;
            $display("[TB] FAIL fault_count: done=%b pass=%b err=%0d expected 1 0 1",
                     done_a, pass_a, err_count_a);
        end
        checks++;
        if ({first_err_addr_a, first_err_exp_a, first_err_got_a} !== {24'd0, 16'hACE1, 16'hACE0}) begin
            failures++;
            $display("[TB] FAIL fault_capture: addr=%0h exp=%0h got=%0h expected 0 ace1 ace0",
                     first_err_addr_a, first_err_exp_a, first_err_got_a);
        end
        fault0[0] = 1'b0;
    endtask

    task automatic test_saturation();
        bit expired;
        invert[1] = 1'b1;
        run_b(8000, expired);
        checks++;
        if (expired || pass_b !== 1'b0 || err_count_b !== 4'hF) begin
            failures++;
            $display("[TB] FAIL sat_count: done=%b pass=%b err=%0h expected 1 0 f",
                     done_b, pass_b, err_count_b);
        end
        checks++;
        if ({first_err_addr_b, first_err_exp_b, first_err_got_b} !== {24'd0, 16'hACE1, 16'h531E}) begin
            failures++;
            $display("[TB] FAIL sat_capture: addr=%0h exp=%0h got=%0h expected 0 ace1 531e",
                     first_err_addr_b, first_err_exp_b, first_err_got_b);
        end
        invert[1] = 1'b0;
    endtask

    task automatic test_timeout();
        int cycles;
        bit expired;
        never_ack[0] = 1'b1;
        run_a(1'b0, 3000, cycles, expired);
        checks++;
        if (expired || {done_a, timeout_a, pass_a, busy_a, bus_a.sdram_req} !== 5'b11000) begin
            failures++;
            $display("[TB] FAIL timeout_flags: done=%b timeout=%b pass=%b busy=%b req=%b expected 1 1 0 0 0",
                     done_a, timeout_a, pass_a, busy_a, bus_a.sdram_req);
        end
        checks++;
        if (cycles < TO || cycles > TO + 10) begin
            failures++;
            $display("[TB] FAIL timeout_latency: got %0d cycles expected about %0d", cycles, TO);
        end
        never_ack[0] = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int cycles = 0;
        bit expired;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        while (!(bus_a.sdram_req && bus_a.sdram_rh_wl) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles >= 3000) begin
            failures++;
            $display("[TB] FAIL midread_reach: no read request within %0d cycles", cycles);
        end
        reset_l = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_a.sdram_req, busy_a} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL midread_reset: req=%b busy=%b expected 0 0", bus_a.sdram_req, busy_a);
        end
        reset_l = 1'b1;
        @(negedge clk);
        acks[0] = 0;
        run_a(1'b1, 6000, cycles, expired);
        checks++;
        if (expired || pass_a !== 1'b1 || acks[0] != 32) begin
            failures++;
            $display("[TB] FAIL restart_with_pokes: done=%b pass=%b acks=%0d expected 1 1 32",
                     done_a, pass_a, acks[0]);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            acks[k] = 0;
            proto_err[k] = 0;
            rd_val[k] = 16'h0;
        end
        test_reset();
        test_lfsr();
        test_clean(1'b0);
        test_fault();
        test_saturation();
        test_timeout();
        test_clean(1'b1);
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_memtest.md
Name: sdram_memtest

Overview:
- Self-contained SDRAM tester that drives the SDRAM controller's request port directly, in place of the SPI-driven manual peek/poke path.
- Write phase: fills address 0..LAST_ADDR with an LFSR pattern.
- Read phase: reads the same range back and compares each word against the regenerated pattern.
- Reports pass/fail, a saturating error count, first-failure details and a handshake watchdog; status goes to LEDs or an SPI status word.

Parameters:
- ADDR_W, 24, SDRAM word address width.
- DATA_W, 16, SDRAM data width.
- LAST_ADDR, 24'hFFFFFF, last address tested (range 0..LAST_ADDR inclusive).
- SEED, 16'hACE1, LFSR seed; must be nonzero.
- TIMEOUT, 1023, max cycles waiting for ack or read data before abort.
- ERRCNT_W, 16, error counter width.

Ports:
- clk  in  1  system clock
- reset_l  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a test when not busy
- busy  out  1  high from accepted start until DONE
- done  out  1  high in DONE until next accepted start
- pass  out  1  valid when done: no mismatch and no timeout
- timeout  out  1  watchdog fired
- err_count  out  ERRCNT_W  mismatching reads, saturating
- first_err_addr  out  ADDR_W  address of first mismatch
- first_err_exp  out  DATA_W  expected data at first mismatch
- first_err_got  out  DATA_W  read data at first mismatch
- sdram_req  out  1  request to controller
- sdram_rh_wl  out  1  1=read, 0=write
- sdram_addr  out  ADDR_W  request address
- sdram_data_w  out  DATA_W  write data
- sdram_ack  in  1  one-cycle pulse: request accepted
- sdram_data_r  in  DATA_W  read data
- sdram_data_r_en  in  1  one-cycle pulse: sdram_data_r valid

Behaviour:
- Reset (reset_l=0 at posedge): state IDLE; all outputs 0. Reset mid-operation drops sdram_req at that edge; there is no partial-state retention.
- Handshake:
  - sdram_req is held high with addr, rh_wl and data_w stable until the cycle sdram_ack=1.
  - req is low in the cycle after ack.
  - At most one outstanding read; the next request issues only after sdram_data_r_en.
- Pattern:
  - Galois LFSR: lfsr_next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Loaded with SEED at the start of each phase; advanced once per address after that address completes.
  - Write data = read expectation = lfsr. Sequence begins ACE1, E270, ...
- FSM:
  - IDLE: start -> WR_REQ; clear addr, stats, done, pass, timeout; lfsr=SEED; busy=1.
  - WR_REQ: req=1, rh_wl=0. On ack: if addr==LAST_ADDR -> RD_REQ (addr=0, lfsr=SEED), else -> WR_NEXT.
  - WR_NEXT: req=0; addr+1, lfsr step -> WR_REQ.
  - RD_REQ: req=1, rh_wl=1. On ack -> RD_WAIT. If data_r_en coincides with ack, compare now -> RD_NEXT.
  - RD_WAIT: req=0. On data_r_en: compare -> RD_NEXT.
  - RD_NEXT: if addr==LAST_ADDR -> DONE, else addr+1, lfsr step -> RD_REQ.
  - DONE: busy=0, done=1, pass=(err_count==0 && !timeout). start -> restart as from IDLE.
- start while busy is ignored.
- Compare: on mismatch, err_count increments, saturating at all-ones. On the first mismatch only, capture first_err_addr/exp/got.
- Watchdog: counter clears on every state change and counts in WR_REQ/RD_REQ/RD_WAIT. Reaching TIMEOUT -> DONE with timeout=1, req=0 in DONE.
- Address compare is exact equality; addr never wraps past LAST_ADDR.
- Data stays on sdram_data_w throughout WR_REQ; it is don't-care during reads but holds the lfsr value.

Decomposition:
- Package sdram_memtest_pkg: FSM state enum, LFSR_TAPS=16'hB400, default widths.
- Sub-module lfsr16_step: combinational next-state of the Galois LFSR. Used in RTL and reused by the bench scoreboard.

Test Plan:
- Reset/idle: hold reset_l=0 for 5 cycles with start=1 -> all outputs 0, no req.
- Clean run, LAST_ADDR=15, behavioural SDRAM model with random 0-5 cycle ack/read latency:
  - 16 writes to addr 0..15, data starting ACE1, E270, then 16 reads of the same range.
  - Result: done=1, pass=1, err_count=0, exactly 32 acks.
- Single-bit fault: model returns 16'hACE0 at addr 0 -> err_count=1, first_err_addr=0, first_err_exp=ACE1, first_err_got=ACE0, pass=0.
- Saturation: ERRCNT_W=4, LAST_ADDR=31, model inverts every read -> err_count=4'hF, first_err_addr=0, first_err_exp=ACE1, first_err_got=531E, pass=0.
- Timeout: model never acks the first write -> after TIMEOUT cycles done=1, timeout=1, pass=0, sdram_req=0.
- Same-cycle ack+data_r_en on reads: clean run still passes.
- Reset mid-read: sdram_req=0 at the next edge and busy=0. A following start runs to pass=1; start pulses while busy are ignored.
